// File: rtl/ccu_op_sequencer.sv
// Operation sequencer: start/done handshake with the register file, result and iteration
// progress tracking, abort/error handling. Define CCU_SEQ_TIMERS_EN to add cycle timers.
module ccu_op_sequencer #(
    parameter logic [3:0] LOADED_MASK = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        operation_start_rd,
    input  logic [3:0]  loaded_rd,
    input  logic        interrupt_soft,
    input  logic        interrupt_abort,
    input  logic        interrupt_error,
    input  logic [31:0] rslt_size_rd,
    input  logic [7:0]  btch_size_rd,
    input  logic        rslt_tlast,
    input  logic        dp_error,
    output logic        dp_start,
    output logic        dp_abort,
    output logic        rw_op_str_reg_en,
    output logic        operation_start_wr,
    output logic        rw_op_dne_reg_en,
    output logic        operation_done_wr,
    output logic [3:0]  loaded_wr,
    output logic        wo_reg_en,
    output logic        wo_reg_rst,
    output logic [5:0]  status,
    output logic [31:0] progress_rslt,
    output logic [31:0] progress_iter,
    output logic [31:0] iter_timer,
    output logic [31:0] iter_latency,
    output logic [31:0] oper_timer,
    output logic [31:0] oper_latency
);

    typedef enum logic [2:0] {
        StIdle, StStr, StBusy, StDone, StAbrt, StErr, StRcvr
    } state_e;

    state_e      state_q, state_d;
    logic        dp_start_q, dp_start_d;
    logic        dp_abort_q, dp_abort_d;
    logic        str_en_q, str_en_d;
    logic        dne_en_q, dne_en_d;
    logic        done_wr_q, done_wr_d;
    logic        wo_en_q, wo_en_d;
    logic        wo_rst_q, wo_rst_d;
    logic        valid_q, valid_d;
    logic [5:0]  status_q, status_d;
    logic [31:0] prog_rslt_q, prog_rslt_d;
    logic [31:0] prog_iter_q, prog_iter_d;
    logic [7:0]  iter_cnt_q, iter_cnt_d;

    logic        any_err, any_stop, count_tlast, iter_done;
    logic [7:0]  batch;

    assign any_err  = interrupt_error | dp_error;
    assign any_stop = interrupt_abort | interrupt_soft;
    assign batch    = (btch_size_rd == 8'd0) ? 8'd1 : btch_size_rd;

    always_comb begin
        state_d     = state_q;
        count_tlast = 1'b0;
        case (state_q)
            StIdle: begin
                if (operation_start_rd && ((loaded_rd & LOADED_MASK) == LOADED_MASK) &&
                    !(any_stop || interrupt_error)) begin
                    state_d = StStr;
                end
            end
            StStr: begin
                if (any_err)                    state_d = StErr;
                else if (rslt_size_rd == 32'd0) state_d = StDone;
                else                            state_d = StBusy;
            end
            StBusy: begin
                // Error beats abort beats the final result; a losing tlast is dropped.
                if (any_err) begin
                    state_d = StErr;
                end else if (any_stop) begin
                    state_d = StAbrt;
                end else if (rslt_tlast) begin
                    count_tlast = 1'b1;
                    if (prog_rslt_q + 32'd1 == rslt_size_rd) state_d = StDone;
                end
            end
            StErr:   state_d = interrupt_soft ? StRcvr : StErr;
            StDone, StAbrt, StRcvr: state_d = any_err ? StErr : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prog_rslt_d = prog_rslt_q;
        prog_iter_d = prog_iter_q;
        iter_cnt_d  = iter_cnt_q;
        iter_done   = 1'b0;
        if (count_tlast) begin
            prog_rslt_d = prog_rslt_q + 32'd1;
            iter_cnt_d  = iter_cnt_q + 8'd1;
            if (iter_cnt_d == batch) begin
                iter_done   = 1'b1;
                iter_cnt_d  = 8'd0;
                prog_iter_d = prog_iter_q + 32'd1;
            end
        end
        if (state_d == StStr) begin
            prog_rslt_d = 32'd0;
            prog_iter_d = 32'd0;
            iter_cnt_d  = 8'd0;
        end

        dp_start_d = (state_d == StStr);
        str_en_d   = (state_d == StStr);
        wo_rst_d   = (state_d == StStr);
        dp_abort_d = (state_d == StAbrt);
        dne_en_d   = (state_d == StDone);
        done_wr_d  = (state_d == StDone);
        wo_en_d    = count_tlast | (state_d == StDone);

        valid_d = valid_q;
        if (state_d == StStr)       valid_d = 1'b0;
        else if (state_d == StDone) valid_d = 1'b1;

        status_d = {state_d == StRcvr, valid_d, state_d == StErr, state_d == StErr,
                    (state_d == StStr) || (state_d == StBusy) || (state_d == StDone),
                    state_d == StIdle};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            dp_start_q  <= 1'b0;
            dp_abort_q  <= 1'b0;
            str_en_q    <= 1'b0;
            dne_en_q    <= 1'b0;
            done_wr_q   <= 1'b0;
            wo_en_q     <= 1'b0;
            wo_rst_q    <= 1'b0;
            valid_q     <= 1'b0;
            status_q    <= 6'b100000;
            prog_rslt_q <= 32'd0;
            prog_iter_q <= 32'd0;
            iter_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            dp_start_q  <= dp_start_d;
            dp_abort_q  <= dp_abort_d;
            str_en_q    <= str_en_d;
            dne_en_q    <= dne_en_d;
            done_wr_q   <= done_wr_d;
            wo_en_q     <= wo_en_d;
            wo_rst_q    <= wo_rst_d;
            valid_q     <= valid_d;
            status_q    <= status_d;
            prog_rslt_q <= prog_rslt_d;
            prog_iter_q <= prog_iter_d;
            iter_cnt_q  <= iter_cnt_d;
        end
    end

`ifdef CCU_SEQ_TIMERS_EN
    logic [31:0] iter_tmr_q, iter_tmr_d;
    logic [31:0] iter_lat_q, iter_lat_d;
    logic [31:0] oper_tmr_q, oper_tmr_d;
    logic [31:0] oper_lat_q, oper_lat_d;

    always_comb begin
        iter_tmr_d = iter_tmr_q;
        iter_lat_d = iter_lat_q;
        oper_tmr_d = oper_tmr_q;
        oper_lat_d = oper_lat_q;
        if (state_q == StBusy) begin
            iter_tmr_d = iter_tmr_q + 32'd1;
            oper_tmr_d = oper_tmr_q + 32'd1;
        end
        if (iter_done) begin
            iter_lat_d = iter_tmr_q + 32'd1;
            iter_tmr_d = 32'd0;
        end
        if (state_d == StDone) oper_lat_d = oper_tmr_q + 32'd1;
        if (state_d == StStr) begin
            iter_tmr_d = 32'd0;
            iter_lat_d = 32'd0;
            oper_tmr_d = 32'd0;
            oper_lat_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_tmr_q <= 32'd0;
            iter_lat_q <= 32'd0;
            oper_tmr_q <= 32'd0;
            oper_lat_q <= 32'd0;
        end else begin
            iter_tmr_q <= iter_tmr_d;
            iter_lat_q <= iter_lat_d;
            oper_tmr_q <= oper_tmr_d;
            oper_lat_q <= oper_lat_d;
        end
    end

    assign iter_timer   = iter_tmr_q;
    assign iter_latency = iter_lat_q;
    assign oper_timer   = oper_tmr_q;
    assign oper_latency = oper_lat_q;
`else
    assign iter_timer   = 32'd0;
    assign iter_latency = 32'd0;
    assign oper_timer   = 32'd0;
    assign oper_latency = 32'd0;
`endif

    assign dp_start           = dp_start_q;
    assign dp_abort           = dp_abort_q;
    assign rw_op_str_reg_en   = str_en_q;
    assign operation_start_wr = 1'b0;
    assign rw_op_dne_reg_en   = dne_en_q;
    assign operation_done_wr  = done_wr_q;
    assign loaded_wr          = 4'b0000;
    assign wo_reg_en          = wo_en_q;
    assign wo_reg_rst         = wo_rst_q;
    assign status             = status_q;
    assign progress_rslt      = prog_rslt_q;
    assign progress_iter      = prog_iter_q;

endmodule
